// File: rtl/vec_pack.sv
// rtl/vec_pack.sv - packs padded fixed-width vectors into a continuous bus-word stream
//
// Purpose:
//   Each input vector arrives as SUB_VEC_NO bus words. The last word of a vector
//   carries only BUS_WIDTH-DELTA valid bits, held in its MSBs. Those valid bits are
//   concatenated MSB-first into a gap-free output stream, and the padding is dropped.
//   After a beat with up_Last is accepted, the remaining bits are flushed. The final
//   output word is zero-padded in its LSBs and marked with dn_Last.
//
// Optional feature:
//   VEC_PACK_FRAMECHK_EN - when defined, err_Framing sets (sticky until reset) when
//   up_Last is accepted on a beat that is not the final sub-vector of a vector.
//   When undefined, err_Framing is tied to 0.
//
// Ports:
//   clk          in   clock, rising edge
//   rstn         in   synchronous active-low reset
//   up_Vector    in   [BUS_WIDTH-1:0] padded sub-vector
//   up_Valid     in   upstream beat valid
//   up_Last      in   final sub-vector of the stream
//   up_Ready     out  upstream ready (registered state only)
//   dn_Vector    out  [BUS_WIDTH-1:0] packed output word
//   dn_Valid     out  downstream beat valid
//   dn_Last      out  final output word of the stream
//   dn_Ready     in   downstream ready
//   err_Framing  out  sticky framing error flag

module vec_pack #(
  parameter int BUS_WIDTH    = 128,
  parameter int VECTOR_WIDTH = 920,
  parameter int SUB_VEC_NO   = (VECTOR_WIDTH + BUS_WIDTH - 1) / BUS_WIDTH
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic [BUS_WIDTH-1:0] up_Vector,
  input  logic                 up_Valid,
  input  logic                 up_Last,
  output logic                 up_Ready,
  output logic [BUS_WIDTH-1:0] dn_Vector,
  output logic                 dn_Valid,
  output logic                 dn_Last,
  input  logic                 dn_Ready,
  output logic                 err_Framing
);

  localparam int DELTA = SUB_VEC_NO * BUS_WIDTH - VECTOR_WIDTH;
  localparam int FW    = $clog2(2 * BUS_WIDTH + 1);
  localparam int CW    = (SUB_VEC_NO > 1) ? $clog2(SUB_VEC_NO) : 1;

  localparam logic [FW-1:0]        W_F       = FW'(BUS_WIDTH);
  localparam logic [FW-1:0]        LAST_F    = FW'(BUS_WIDTH - DELTA);
  localparam logic [CW-1:0]        CNT_MAX   = CW'(SUB_VEC_NO - 1);
  localparam logic [BUS_WIDTH-1:0] LAST_MASK = {BUS_WIDTH{1'b1}} << DELTA;

  // Accumulator holds the unemitted bits left-aligned. Every bit below the fill
  // level is kept at zero, so a new beat can simply be OR-ed in at the fill point.
  logic [2*BUS_WIDTH-1:0] r_acc;
  logic [FW-1:0]          r_fill;
  logic [CW-1:0]          r_cnt;
  logic                   r_flush;

  logic [2*BUS_WIDTH-1:0] w_acc_next;
  logic [FW-1:0]          w_fill_next;
  logic [CW-1:0]          w_cnt_next;
  logic                   w_flush_next;

  logic                   w_push;
  logic                   w_pop;
  logic                   w_last_sub;
  logic [FW-1:0]          w_contrib;
  logic [BUS_WIDTH-1:0]   w_in;
  logic [2*BUS_WIDTH-1:0] w_acc_pp;
  logic [FW-1:0]          w_fill_pp;
  logic [2*BUS_WIDTH-1:0] w_ins;

  assign up_Ready  = (r_fill <= W_F) && !r_flush;
  assign dn_Valid  = (r_fill >= W_F) || (r_flush && (r_fill != '0));
  assign dn_Last   = r_flush && (r_fill <= W_F);
  assign dn_Vector = r_acc[2*BUS_WIDTH-1:BUS_WIDTH];

  assign w_push     = up_Valid && up_Ready;
  assign w_pop      = dn_Valid && dn_Ready;
  assign w_last_sub = (r_cnt == CNT_MAX);
  assign w_contrib  = w_last_sub ? LAST_F : W_F;
  assign w_in       = w_last_sub ? (up_Vector & LAST_MASK) : up_Vector;

  // The pop is applied first, and the new beat is then inserted at the post-pop
  // fill level. This makes a simultaneous push and pop lossless.
  assign w_acc_pp  = w_pop ? (r_acc << BUS_WIDTH) : r_acc;
  assign w_fill_pp = w_pop ? (r_fill - W_F) : r_fill;
  assign w_ins     = {w_in, {BUS_WIDTH{1'b0}}} >> w_fill_pp;

  always_comb begin
    w_acc_next   = r_acc;
    w_fill_next  = r_fill;
    w_cnt_next   = r_cnt;
    w_flush_next = r_flush;
    if (w_pop && dn_Last) begin
      // Final word leaves: the stream is closed. up_Ready is low during a flush,
      // so no push can coincide with this pop.
      w_acc_next   = '0;
      w_fill_next  = '0;
      w_cnt_next   = '0;
      w_flush_next = 1'b0;
    end else begin
      w_acc_next  = w_acc_pp | (w_push ? w_ins : '0);
      w_fill_next = w_fill_pp + (w_push ? w_contrib : '0);
      if (w_push) begin
        w_cnt_next   = w_last_sub ? '0 : r_cnt + CW'(1);
        w_flush_next = r_flush | up_Last;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_acc   <= '0;
      r_fill  <= '0;
      r_cnt   <= '0;
      r_flush <= 1'b0;
    end else begin
      r_acc   <= w_acc_next;
      r_fill  <= w_fill_next;
      r_cnt   <= w_cnt_next;
      r_flush <= w_flush_next;
    end
  end

`ifdef VEC_PACK_FRAMECHK_EN
  logic r_err;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_err <= 1'b0;
    end else if (w_push && up_Last && !w_last_sub) begin
      r_err <= 1'b1;
    end
  end

  assign err_Framing = r_err;
`else
  assign err_Framing = 1'b0;
`endif

endmodule

// File: tb/tb_vec_pack.sv
// tb/tb_vec_pack.sv - scoreboard testbench for vec_pack

module tb_vec_pack;

  localparam int BW  = 128;
  localparam int VW  = 920;
  localparam int SVN = 8;
  localparam int DW  = SVN * BW - VW;

`ifdef VEC_PACK_FRAMECHK_EN
  localparam bit FRAME_ON = 1'b1;
`else
  localparam bit FRAME_ON = 1'b0;
`endif

  logic          clk;
  logic          rstn;
  logic [BW-1:0] up_Vector;
  logic          up_Valid, up_Last, up_Ready;
  logic [BW-1:0] dn_Vector;
  logic          dn_Valid, dn_Last, dn_Ready;
  logic          err_Framing;

  logic [BW-1:0] u2_Vector, d2_Vector;
  logic          u2_Valid, u2_Last, u2_Ready;
  logic          d2_Valid, d2_Last, d2_Ready;
  logic          err2;

  vec_pack #(.BUS_WIDTH(BW), .VECTOR_WIDTH(VW)) dut (
    .clk(clk), .rstn(rstn),
    .up_Vector(up_Vector), .up_Valid(up_Valid), .up_Last(up_Last), .up_Ready(up_Ready),
    .dn_Vector(dn_Vector), .dn_Valid(dn_Valid), .dn_Last(dn_Last), .dn_Ready(dn_Ready),
    .err_Framing(err_Framing)
  );

  vec_pack #(.BUS_WIDTH(BW), .VECTOR_WIDTH(256)) dut2 (
    .clk(clk), .rstn(rstn),
    .up_Vector(u2_Vector), .up_Valid(u2_Valid), .up_Last(u2_Last), .up_Ready(u2_Ready),
    .dn_Vector(d2_Vector), .dn_Valid(d2_Valid), .dn_Last(d2_Last), .dn_Ready(d2_Ready),
    .err_Framing(err2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [BW-1:0] data;
    bit            last;
  } exp_t;

  exp_t          exp_q[$];
  logic [BW-1:0] stim_q[$];
  int            checks = 0;
  int            errors = 0;
  int            pop_cnt = 0;
  int            fill_m = 0;
  bit            flush_m = 0;
  int            cnt_m = 0;
  bit            err_m = 0;
  bit            rand_ready = 0;
  bit            hold_on = 0;
  logic [BW-1:0] hold_vec;
  bit            hold_last;
  bit            acc_b, pop_b;

  task automatic check(input string nm, input logic [BW-1:0] act, input logic [BW-1:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp_v, $time);
    end
  endtask

  function automatic logic [BW-1:0] rnd_word();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Reference: keep the valid bits of each beat (all bits, or the top BW-DW bits on
  // the last sub-vector of a vector), form one long bit string, and cut it into
  // bus words. The tail word is zero-filled.
  task automatic build_expected(input int n);
    bit            bits[$];
    logic [BW-1:0] w;
    exp_t          e;
    for (int i = 0; i < n; i++) begin
      int nb;
      nb = ((i % SVN) == SVN - 1) ? (BW - DW) : BW;
      w  = stim_q[i];
      for (int b = BW - 1; b >= BW - nb; b--) bits.push_back(w[b]);
    end
    while (bits.size() > 0) begin
      w = '0;
      for (int j = 0; j < BW; j++)
        if (bits.size() > 0) w[BW-1-j] = bits.pop_front();
      e.data = w;
      e.last = (bits.size() == 0);
      exp_q.push_back(e);
    end
  endtask

  // Runs at posedge+1. Sends n beats and stops early at beat index stop_after
  // (when stop_after >= 0). gap_pct sets the chance of idle cycles between beats.
  task automatic run_stream(input int n, input int gap_pct, input int stop_after);
    bit got;
    pop_cnt = 0;
    stim_q.delete();
    for (int i = 0; i < n; i++) stim_q.push_back(rnd_word());
    build_expected(n);
    for (int i = 0; i < n; i++) begin
      if (i == stop_after) break;
      for (int g = 0; g < 4 && gap_pct > 0 && $urandom_range(99) < gap_pct; g++) begin
        up_Valid = 1'b0;
        @(posedge clk); #1;
      end
      up_Valid  = 1'b1;
      up_Vector = stim_q[i];
      up_Last   = (i == n - 1);
      got = 1'b0;
      for (int t = 0; t < 2000 && !got; t++) begin
        @(negedge clk);
        got = up_Ready;
        @(posedge clk); #1;
      end
      if (!got) begin
        checks++; errors++;
        $display("FAIL up_Ready_timeout: got 0 expected 1 at beat %0d", i);
        break;
      end
    end
    up_Valid = 1'b0;
    up_Last  = 1'b0;
  endtask

  task automatic drain(input int exp_beats);
    int t;
    t = 0;
    while ((exp_q.size() != 0 || fill_m != 0 || flush_m) && t < 5000) begin
      @(posedge clk);
      t++;
    end
    check("drain_done", (t < 5000), 1'b1);
    check("beat_count", pop_cnt, exp_beats);
    @(posedge clk); #1;
  endtask

  initial begin
    dn_Ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      dn_Ready = rand_ready ? 1'($urandom_range(1)) : 1'b1;
    end
  end

  // Monitor: checks the handshake flags against the fill/flush model every cycle,
  // pops the scoreboard on each output beat, and checks output stability while stalled.
  always @(negedge clk) begin
    if (!rstn) begin
      exp_q.delete();
      fill_m  = 0;
      flush_m = 0;
      cnt_m   = 0;
      err_m   = 0;
      hold_on = 0;
    end else begin
      check("up_Ready", up_Ready, (fill_m <= BW) && !flush_m);
      check("dn_Valid", dn_Valid, (fill_m >= BW) || (flush_m && fill_m > 0));
      check("dn_Last", dn_Last, flush_m && (fill_m <= BW));
      check("err_Framing", err_Framing, err_m);
      if (hold_on) begin
        check("hold_vec", dn_Vector, hold_vec);
        check("hold_valid", dn_Valid, 1'b1);
        check("hold_last", dn_Last, hold_last);
      end
      acc_b = up_Valid && up_Ready;
      pop_b = dn_Valid && dn_Ready;
      if (pop_b) begin
        pop_cnt++;
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_beat: got %h expected none", dn_Vector);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("dn_Vector", dn_Vector, e.data);
          check("dn_Last_at_pop", dn_Last, e.last);
        end
      end
      if (pop_b && dn_Last) begin
        fill_m  = 0;
        flush_m = 0;
        cnt_m   = 0;
      end else begin
        if (pop_b) fill_m -= BW;
        if (acc_b) begin
          fill_m += (cnt_m == SVN - 1) ? (BW - DW) : BW;
          if (FRAME_ON && up_Last && cnt_m != SVN - 1) err_m = 1;
          if (up_Last) flush_m = 1;
          cnt_m = (cnt_m + 1) % SVN;
        end
      end
      hold_on   = dn_Valid && !dn_Ready;
      hold_vec  = dn_Vector;
      hold_last = dn_Last;
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [BW-1:0] prev;
    rstn = 1'b0;
    up_Valid = 1'b0; up_Last = 1'b0; up_Vector = '0;
    u2_Valid = 1'b0; u2_Last = 1'b0; u2_Vector = '0; d2_Ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rstn = 1'b1;
    @(negedge clk);
    check("rst_dn_Valid", dn_Valid, 1'b0);
    check("rst_dn_Vector", dn_Vector, '0);
    check("rst_dn_Last", dn_Last, 1'b0);
    check("rst_up_Ready", up_Ready, 1'b1);
    check("rst_err", err_Framing, 1'b0);
    @(posedge clk); #1;

    // Two vectors: 1840 bits -> 14 full words + one 48-bit tail.
    run_stream(16, 0, -1);
    drain(15);
    // Sixteen vectors: 14720 bits -> 115 full words.
    run_stream(128, 0, -1);
    drain(115);
    // Thirty-two vectors with random backpressure and gaps.
    rand_ready = 1;
    run_stream(256, 30, -1);
    drain(230);
    rand_ready = 0;

    // Reset after beat 5 of the first vector, then a fresh stream.
    run_stream(16, 0, 5);
    rstn = 1'b0;
    @(posedge clk); #1 rstn = 1'b1;
    @(negedge clk);
    check("midrst_dn_Valid", dn_Valid, 1'b0);
    check("midrst_dn_Vector", dn_Vector, '0);
    @(posedge clk); #1;
    run_stream(16, 0, -1);
    drain(15);

    // up_Last on beat 4: the stream closes early and the error flag is sticky.
    run_stream(4, 0, -1);
    drain(4);
    check("frame_err", err_Framing, FRAME_ON);
    run_stream(16, 0, -1);
    drain(15);
    check("frame_err_sticky", err_Framing, FRAME_ON);
    rstn = 1'b0;
    @(posedge clk); #1 rstn = 1'b1;
    @(negedge clk);
    check("frame_err_cleared", err_Framing, 1'b0);
    @(posedge clk); #1;

    // DELTA=0: pass-through with one-cycle latency.
    prev = '0;
    for (int i = 0; i < 20; i++) begin
      u2_Vector = rnd_word();
      u2_Valid  = 1'b1;
      u2_Last   = (i == 19);
      @(negedge clk);
      check("pt_up_Ready", u2_Ready, 1'b1);
      if (i > 0) begin
        check("pt_valid", d2_Valid, 1'b1);
        check("pt_data", d2_Vector, prev);
        check("pt_last", d2_Last, 1'b0);
      end
      prev = u2_Vector;
      @(posedge clk); #1;
    end
    u2_Valid = 1'b0;
    u2_Last  = 1'b0;
    @(negedge clk);
    check("pt_final_valid", d2_Valid, 1'b1);
    check("pt_final_data", d2_Vector, prev);
    check("pt_final_last", d2_Last, 1'b1);
    @(posedge clk); #1;
    @(negedge clk);
    check("pt_idle", d2_Valid, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/vec_pack.md
VEC_PACK -- requirements
Module: vec_pack

Interface
REQ-001 SHALL have parameter BUS_WIDTH, default 128, bus word width in bits.
REQ-002 SHALL have parameter VECTOR_WIDTH, default 920, bits per vector.
REQ-003 SHALL have parameter SUB_VEC_NO, default ceil(VECTOR_WIDTH/BUS_WIDTH), bus words per padded vector; DELTA = SUB_VEC_NO*BUS_WIDTH - VECTOR_WIDTH is a derived localparam.
REQ-004 SHALL have port clk  input  1  clock; all logic on rising edge.
REQ-005 SHALL have port rstn  input  1  reset, synchronous, active-low.
REQ-006 SHALL have port up_Vector  input  BUS_WIDTH  padded sub-vector, one vector per SUB_VEC_NO words, last word valid in bits [BUS_WIDTH-1:DELTA].
REQ-007 SHALL have ports up_Valid input 1, up_Last input 1 (final sub-vector of stream), up_Ready output 1, with valid/ready beat semantics.
REQ-008 SHALL have ports dn_Vector output BUS_WIDTH (packed continuous stream), dn_Valid output 1, dn_Last output 1, dn_Ready input 1.
REQ-009 SHALL have port err_Framing  output  1  sticky framing error flag.

Function
REQ-010 Packing: output stream SHALL be the MSB-first concatenation of input vectors; first vector bit VECTOR_WIDTH-1 lands at dn_Vector[BUS_WIDTH-1] of the first output word; padding bits [DELTA-1:0] of each final sub-vector are discarded.
REQ-011 A sub-vector counter (0..SUB_VEC_NO-1) SHALL advance on each accepted beat and wrap to 0 after SUB_VEC_NO-1; beat at count SUB_VEC_NO-1 contributes BUS_WIDTH-DELTA bits, all others BUS_WIDTH bits.
REQ-012 An accumulator of 2*BUS_WIDTH bits with fill count (0..2*BUS_WIDTH) SHALL hold unemitted bits left-aligned.
REQ-013 up_Ready SHALL be 1 iff fill <= BUS_WIDTH and no flush pending; it SHALL depend on registers only (no path from dn_Ready).
REQ-014 dn_Valid SHALL be 1 iff fill >= BUS_WIDTH, or flush pending and fill > 0; dn_Vector SHALL be the accumulator top BUS_WIDTH bits, zero below fill when fill < BUS_WIDTH.
REQ-015 Latency: a beat accepted in cycle t that makes fill >= BUS_WIDTH SHALL give dn_Valid=1 in cycle t+1.
REQ-016 Simultaneous pop (dn_Valid&dn_Ready) and push (up_Valid&up_Ready) in one cycle SHALL give fill_next = fill - BUS_WIDTH*pop + contribution*push, with no bit lost or duplicated.
REQ-017 Accepting a beat with up_Last=1 SHALL set flush pending; while pending, up_Ready=0.
REQ-018 dn_Last SHALL equal flush pending AND fill <= BUS_WIDTH, i.e. only on the final output beat; final beat zero-pads its LSBs.
REQ-019 Pop of the dn_Last beat SHALL clear flush pending, fill and the sub-vector counter in the same edge.
REQ-020 dn_Vector/dn_Valid/dn_Last SHALL hold stable while dn_Valid=1 and dn_Ready=0.
REQ-021 DELTA=0 SHALL yield pure pass-through with one-cycle latency; SUB_VEC_NO=1 SHALL treat every beat as final sub-vector.

Reset
REQ-022 On rstn=0 at a clock edge: fill=0, accumulator=0, sub-vector counter=0, flush pending=0, err_Framing=0; hence dn_Valid=0, dn_Last=0, dn_Vector=0, up_Ready=1 from the following cycle.
REQ-023 Reset mid-stream SHALL discard all buffered bits; no partial word emitted afterwards.

Configuration
REQ-024 With macro VEC_PACK_FRAMECHK_EN defined, err_Framing SHALL set when up_Last=1 is accepted with sub-vector counter != SUB_VEC_NO-1, and stay set until reset; that beat is still packed and flushed normally.
REQ-025 Without VEC_PACK_FRAMECHK_EN, err_Framing SHALL be constant 0 and no check logic synthesised.

Verification (BUS_WIDTH=128, VECTOR_WIDTH=920, SUB_VEC_NO=8, DELTA=104 unless noted)
REQ-026 2 vectors (16 beats, up_Last on beat 16), dn_Ready=1 -> 15 output beats; beat 15 has 48 valid MSBs, 80 zero LSBs, dn_Last=1 only there.
REQ-027 16 vectors (128 beats, up_Last on 128) -> exactly 115 full beats, dn_Last on beat 115, bits match reference concatenation.
REQ-028 Random dn_Ready (50%) and up_Valid gaps on 32 vectors -> output bit-identical to REQ-027 model, no stall deadlock, up_Ready=0 whenever fill > 128.
REQ-029 rstn=0 for one cycle after beat 5 of vector 1 -> dn_Valid=0 next cycle; fresh 2-vector stream then reproduces REQ-026.
REQ-030 FRAMECHK_EN defined, up_Last on beat 4 -> err_Framing=1 from next cycle, stays 1; output = 512 bits packed as 4 full beats, dn_Last on beat 4.
REQ-031 VECTOR_WIDTH=256, BUS_WIDTH=128 -> each output beat equals input beat one cycle later.
